// File: rtl/term_quant_pkg.sv
// Shared types and engine constants for the term quantisation datapath.
// The engine's per-lane counters are ENG_CNT_W bits wide, which sets the longest legal group.
package term_quant_pkg;

    localparam int NUM_LANES     = 4;
    localparam int ENG_CNT_W     = 3;
    localparam int MAX_GROUP_LEN = 2**ENG_CNT_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FINISH
    } sched_state_e;

endpackage

// File: rtl/term_group_scheduler_if.sv
// Valid/ready stream signals between the term source, the scheduler and the downstream accumulator.
interface term_group_scheduler_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, out_last
    );

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, out_last
    );

endinterface

// File: rtl/term_group_scheduler_out_stage.sv
// term_out_stage: a one-entry holding register that mirrors the engine's output register.
// It owns out_valid/out_last and produces in_ready/accept for the scheduler FSM.
module term_out_stage (
    input  logic clk,
    input  logic reset,
    input  logic stream_en,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    input  logic beat_last,
    output logic in_ready,
    output logic accept,
    output logic out_valid,
    output logic out_last
);

    logic out_valid_d, out_valid_q;
    logic out_last_d,  out_last_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        in_ready    = stream_en & (~out_valid_q | out_ready);
        accept      = in_valid & in_ready;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = beat_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: rtl/term_group_scheduler.sv
// Sequences the 4-lane term comparator/truncator over a job of back-to-back term groups,
// clearing the engine between groups and gating it through power_on when no beat is taken.
module term_group_scheduler
    import term_quant_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int GRP_W         = 8,
    parameter int MAX_GROUP_LEN = term_quant_pkg::MAX_GROUP_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_mode,
    input  logic [CNT_W-1:0]       cfg_group_len,
    input  logic [GRP_W-1:0]       cfg_num_groups,
    output logic                   busy,
    output logic                   done,
    output logic                   eng_sel,
    output logic                   eng_power_on,
    output logic                   eng_reset,
    term_group_scheduler_if.slave  bus
);

    sched_state_e state_d, state_q;
    logic [CNT_W-1:0] beat_cnt_d, beat_cnt_q;
    logic [GRP_W-1:0] grp_cnt_d, grp_cnt_q;
    logic [CNT_W-1:0] len_d, len_q;
    logic [GRP_W-1:0] num_d, num_q;
    logic             mode_d, mode_q;
    logic             done_d, done_q;

    logic [CNT_W-1:0] clamped_len;
    logic             beat_last, grp_last;
    logic             stream_en, accept;

    assign clamped_len = (cfg_group_len > CNT_W'(MAX_GROUP_LEN)) ? CNT_W'(MAX_GROUP_LEN)
                                                                 : cfg_group_len;
    assign beat_last   = (beat_cnt_q == len_q - CNT_W'(1));
    assign grp_last    = (grp_cnt_q == num_q - GRP_W'(1));
    assign stream_en   = (state_q == S_STREAM) & ~abort;

    term_out_stage u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .stream_en (stream_en),
        .flush     (abort),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .beat_last (beat_last),
        .in_ready  (bus.in_ready),
        .accept    (accept),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last)
    );

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        len_d        = len_q;
        num_d        = num_q;
        mode_d       = mode_q;
        done_d       = 1'b0;
        eng_power_on = 1'b0;
        eng_reset    = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            grp_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_d      = clamped_len;
                        num_d      = cfg_num_groups;
                        mode_d     = cfg_mode;
                        beat_cnt_d = '0;
                        grp_cnt_d  = '0;
                        state_d    = (clamped_len == '0 || cfg_num_groups == '0) ? S_FINISH
                                                                                 : S_CLEAR;
                    end
                end
                // The engine clear leaves its output register alone, so a pending beat survives.
                S_CLEAR: begin
                    eng_power_on = 1'b1;
                    eng_reset    = 1'b1;
                    beat_cnt_d   = '0;
                    state_d      = S_STREAM;
                end
                S_STREAM: begin
                    eng_power_on = accept;
                    if (accept) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (beat_last) begin
                            if (grp_last) begin
                                state_d = S_FINISH;
                            end else begin
                                grp_cnt_d = grp_cnt_q + GRP_W'(1);
                                state_d   = S_CLEAR;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    if (!(bus.out_valid && !bus.out_ready)) begin
                        done_d     = 1'b1;
                        beat_cnt_d = '0;
                        grp_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            grp_cnt_q  <= '0;
            len_q      <= '0;
            num_q      <= '0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            len_q      <= len_d;
            num_q      <= num_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign eng_sel = busy & mode_q;

endmodule

// File: tb/tb_term_group_scheduler.sv
// Randomised scoreboard bench for term_group_scheduler: the driver pushes the expected
// out_last sequence of each job, a negedge monitor pops and checks every delivered beat.
module tb_term_group_scheduler;

    localparam int CNT_W = 4;
    localparam int GRP_W = 8;
    localparam int MAX_LEN = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_mode = 1'b0;
    logic [CNT_W-1:0] cfg_group_len = '0;
    logic [GRP_W-1:0] cfg_num_groups = '0;
    logic             busy, done, eng_sel, eng_power_on, eng_reset;

    term_group_scheduler_if bus ();

    term_group_scheduler #(.CNT_W(CNT_W), .GRP_W(GRP_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_mode       (cfg_mode),
        .cfg_group_len  (cfg_group_len),
        .cfg_num_groups (cfg_num_groups),
        .busy           (busy),
        .done           (done),
        .eng_sel        (eng_sel),
        .eng_power_on   (eng_power_on),
        .eng_reset      (eng_reset),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit exp_last_q[$];
    bit cur_mode  = 1'b0;
    int acc_cnt   = 0;
    int rst_cnt   = 0;
    int pwr_cnt   = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    bit prev_stall = 1'b0;
    bit prev_last  = 1'b0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops, handshake rules and per-job event counts.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_last_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("out_last", int'(bus.out_last), int'(exp_last_q.pop_front()));
            end
            if (prev_stall) check("held_beat", {bus.out_valid, bus.out_last}, {1'b1, prev_last});
            if (bus.out_valid && !bus.out_ready) check("in_ready_stall", int'(bus.in_ready), 0);
            if (eng_reset) check("clear_in_ready", int'(bus.in_ready), 0);
            if (!busy) check("idle_in_ready", int'(bus.in_ready), 0);
            check("eng_power_on", int'(eng_power_on),
                  int'(eng_reset | (bus.in_valid & bus.in_ready)));
            check("eng_sel", int'(eng_sel), busy ? int'(cur_mode) : 0);
            if (done) begin
                check("done_drained", int'(bus.out_valid), 0);
                check("done_queue_empty", exp_last_q.size(), 0);
                check("busy_with_done", int'(busy), 0);
                done_cyc = cyc;
            end
            prev_stall = bus.out_valid & ~bus.out_ready & ~abort;
            prev_last  = bus.out_last;
            acc_cnt  += int'(bus.in_valid & bus.in_ready);
            rst_cnt  += int'(eng_reset);
            pwr_cnt  += int'(eng_power_on);
            done_cnt += int'(done);
        end
    end

    task automatic clear_counts();
        acc_cnt = 0; rst_cnt = 0; pwr_cnt = 0; done_cnt = 0;
    endtask

    task automatic issue_start(bit mode, int len, int num, output int total);
        int eff;
        eff   = (len > MAX_LEN) ? MAX_LEN : len;
        total = (eff == 0 || num == 0) ? 0 : eff * num;
        clear_counts();
        @(posedge clk); #1;
        cfg_mode       = mode;
        cfg_group_len  = CNT_W'(len);
        cfg_num_groups = GRP_W'(num);
        start          = 1'b1;
        cur_mode       = mode;
        start_cyc      = cyc;
        if (total > 0)
            for (int g = 0; g < num; g++)
                for (int b = 0; b < eff; b++) exp_last_q.push_back(b == eff - 1);
        @(posedge clk); #1;
        start          = 1'b0;
        cfg_mode       = 1'($urandom);
        cfg_group_len  = CNT_W'($urandom);
        cfg_num_groups = GRP_W'($urandom);
        @(negedge clk);
        check("start_busy", int'(busy), 1);
        check("start_clear", int'(eng_reset), int'(total > 0));
    endtask

    // iv_mode: 0 always valid, 1 toggling, 2 random. or_mode: 0 always ready, 1 three-cycle stall, 2 random.
    task automatic run_job(bit mode, int len, int num, int iv_mode, int or_mode);
        int total;
        issue_start(mode, len, num, total);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            case (iv_mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (c % 2 == 0);
                default: bus.in_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !(c >= 3 && c <= 5);
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        check("accepted_beats", acc_cnt, total);
        check("clear_cycles", rst_cnt, (total > 0) ? num : 0);
        check("power_on_cycles", pwr_cnt, total + ((total > 0) ? num : 0));
        check("done_pulses", done_cnt, 1);
        check("queue_drained", exp_last_q.size(), 0);
        if (total == 0) check("empty_done_latency", done_cyc - start_cyc, 2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_last_q.delete();
    endtask

    task automatic check_all_zero(string name);
        check(name, {busy, done, bus.in_ready, bus.out_valid, bus.out_last,
                     eng_sel, eng_power_on, eng_reset}, 0);
    endtask

    initial begin
        int total;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_job(1'b0, 4, 2, 0, 0);   // basic job
        run_job(1'b0, 4, 2, 1, 0);   // source bubbles
        run_job(1'b1, 4, 2, 0, 1);   // downstream backpressure
        run_job(1'b0, 12, 2, 0, 0);  // clamp to 7
        run_job(1'b1, 5, 0, 0, 0);   // zero groups
        run_job(1'b0, 0, 3, 0, 0);   // zero length

        // Abort on beat 3 of the first group.
        issue_start(1'b0, 4, 2, total);
        for (int c = 0; c < 50 && acc_cnt < 2; c++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
        end
        check("abort_reached_beat3", acc_cnt, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", int'(busy), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_accepts", acc_cnt, 2);
        bus.in_valid = 1'b0;
        exp_last_q.delete();
        run_job(1'b1, 4, 2, 0, 0);

        // Asynchronous reset mid-stream.
        issue_start(1'b0, 4, 2, total);
        repeat (4) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        exp_last_q.delete();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        run_job(1'b0, 4, 1, 0, 0);

        for (int j = 0; j < 20; j++)
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3), 2, 2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
